// File: rtl/alu_seq_if.sv
// Instruction handshake and ALU port bundle for the SIC-4 issue/writeback sequencer.
// The master modport is the sequencer; the slave side holds the instruction source and the ALU.
interface alu_seq_if;
  logic       instr_valid;
  logic       instr_ready;
  logic [7:0] instr;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [1:0] alu_op;
  logic [7:0] alu_res;
  logic       done;

  modport master (
    input  instr_valid,
    input  instr,
    input  alu_res,
    output instr_ready,
    output alu_a,
    output alu_b,
    output alu_op,
    output done
  );

  modport slave (
    output instr_valid,
    output instr,
    output alu_res,
    input  instr_ready,
    input  alu_a,
    input  alu_b,
    input  alu_op,
    input  done
  );
endinterface

// File: rtl/alu_seq.sv
// Multi-cycle issue/writeback sequencer for the 8-bit SIC-4 ALU with a 4x8 register file.
// Optional zero/neg result flags are built when ALU_SEQ_FLAGS_EN is defined.
module alu_seq (
  input  logic       clk,
  input  logic       rst,
  alu_seq_if.master  bus,
  input  logic       ld_en,
  input  logic [1:0] ld_sel,
  input  logic [7:0] ld_data,
  input  logic [1:0] dbg_sel,
  output logic [7:0] dbg_data
`ifdef ALU_SEQ_FLAGS_EN
  ,
  output logic       zero,
  output logic       neg
`endif
);

  localparam int unsigned Width = 8;
  localparam int unsigned NRegs = 4;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRead  = 2'd1;
  localparam logic [1:0] StExec  = 2'd2;
  localparam logic [1:0] StWrite = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [Width-1:0] ir_q, ir_d;
  logic [Width-1:0] opa_q, opa_d;
  logic [Width-1:0] opb_q, opb_d;
  logic [1:0]       op_q, op_d;
  logic [Width-1:0] res_q, res_d;
  logic [Width-1:0] rf_q [NRegs];
  logic [Width-1:0] rf_d [NRegs];

  // Instruction register fields.
  logic [1:0] ir_op, ir_rd, ir_rs, ir_rt;
  assign ir_op = ir_q[7:6];
  assign ir_rd = ir_q[5:4];
  assign ir_rs = ir_q[3:2];
  assign ir_rt = ir_q[1:0];

  // A pending load always takes priority over instruction acceptance.
  assign bus.instr_ready = (state_q == StIdle) && !ld_en && !rst;
  assign bus.done        = (state_q == StWrite) && !rst;

  // Operand/op registers only change in READ, so the ALU port holds its last EXEC values.
  assign bus.alu_a  = opa_q;
  assign bus.alu_b  = opb_q;
  assign bus.alu_op = op_q;

  assign dbg_data = rf_q[dbg_sel];

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    op_d    = op_q;
    res_d   = res_q;
    rf_d    = rf_q;
    case (state_q)
      StIdle: begin
        if (ld_en) begin
          rf_d[ld_sel] = ld_data;
        end else if (bus.instr_valid) begin
          ir_d    = bus.instr;
          state_d = StRead;
        end
      end
      StRead: begin
        opa_d   = rf_q[ir_rs];
        opb_d   = rf_q[ir_rt];
        op_d    = ir_op;
        state_d = StExec;
      end
      StExec: begin
        res_d   = bus.alu_res;
        state_d = StWrite;
      end
      StWrite: begin
        rf_d[ir_rd] = res_q;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      ir_q    <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      op_q    <= '0;
      res_q   <= '0;
      for (int i = 0; i < NRegs; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      op_q    <= op_d;
      res_q   <= res_d;
      rf_q    <= rf_d;
    end
  end

`ifdef ALU_SEQ_FLAGS_EN
  logic zero_q, neg_q;

  // Flags track only ALU writebacks; direct loads leave them alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
    end else if (state_q == StWrite) begin
      zero_q <= (res_q == '0);
      neg_q  <= res_q[Width-1];
    end
  end

  assign zero = zero_q;
  assign neg  = neg_q;
`endif

endmodule
